jtag_scan_master: RTL and testbench
===================================

Name: jtag_scan_master

Overview:
- System-clock-domain JTAG master that drives the tck/tms/tdi/trst_ pins of the JTAG GPIO top level. It lets on-chip logic or a test bench perform IR and DR scans without a cable.
- Takes scan commands over a valid/ready interface and walks the TAP state machine with fixed TMS sequences. Returns the captured TDO bits over a response interface.
- Sits directly upstream of the JTAG TAP/GPIO top level when it is built with the generic TAP.

Parameters:
MAX_LEN, 32, maximum scan length in bits (>=1)
CLK_DIV, 4, clk cycles per TCK half-period (>=1); one TCK period = 2*CLK_DIV clk cycles
LEN_W, $clog2(MAX_LEN+1), width of cmd_len

Ports:
clk  input  1  system clock
reset_  input  1  asynchronous active-low reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when valid&ready
cmd_op  input  2  0=TLR reset, 1=IR scan, 2=DR scan, 3=reserved (treated as TLR)
cmd_len  input  LEN_W  scan length in bits, 1..MAX_LEN (ignored for TLR)
cmd_tdi  input  MAX_LEN  data to shift, LSB first
rsp_valid  output  1  response valid, held until rsp_ready
rsp_ready  input  1  response consumed
rsp_tdo  output  MAX_LEN  captured TDO, bit i = TDO seen while shifting cmd_tdi[i]; bits >= len are 0
jtag_trst_  output  1  TAP reset, active low
jtag_tck  output  1  TCK
jtag_tms  output  1  TMS
jtag_tdi  output  1  TDI
jtag_tdo  input  1  TDO from target

Behaviour:
- Reset values while reset_ is low:
  - jtag_trst_=0, jtag_tck=0, jtag_tms=1, jtag_tdi=0.
  - cmd_ready=0, rsp_valid=0, rsp_tdo=0, state=AUTO_TLR.
- jtag_trst_ rises on the first clk edge after reset_ deasserts.
- The AUTO_TLR state then runs the TLR sequence with no response. cmd_ready rises only after it completes.
- TCK generation:
  - A divider counts 0..CLK_DIV-1 and toggles jtag_tck at terminal count, only while state is not IDLE or RSP.
  - TCK idles low; every sequence starts and ends with tck low.
- jtag_tms and jtag_tdi update in the clk cycle that drives tck high->low; the first bit is driven before the first rising edge.
- jtag_tdo is sampled in the clk cycle that drives tck low->high.
- States: AUTO_TLR, IDLE, TLR, HDR, SHIFT, TRL, RSP.
- IDLE: cmd_ready=1. On cmd_valid, latch op/len/tdi, drop cmd_ready, and go to TLR or HDR.
- cmd_len=0 or >MAX_LEN: clamp to MAX_LEN for IR/DR; no error flag.
- TLR: TMS 1,1,1,1,1,0 (6 rising edges); ends in Run-Test/Idle.
- HDR:
  - IR scan TMS = 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
  - DR scan TMS = 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - jtag_tdi=0 during HDR.
- SHIFT: len rising edges. jtag_tdi=tdi[i], TMS=0 except on the last bit, where TMS=1 (Exit1).
- TDO captured on SHIFT rising edges only, into bit i.
- TRL: TMS 1,0 (Update, Run-Test/Idle), jtag_tdi=0.
- Total rising edges: IR=len+6, DR=len+5, TLR=6.
- RSP:
  - Entered after the last TRL falling edge (TLR ops also produce a response, with rsp_tdo=0).
  - rsp_valid=1 and rsp_tdo stable until rsp_ready.
  - On valid&ready, go to IDLE; cmd_ready=1 in the next cycle.
  - A new command is never accepted while rsp_valid=1.
- cmd_valid held during a busy operation is ignored until cmd_ready.
- Reset mid-operation: immediate return to reset values; the TAP is re-synchronised by AUTO_TLR, and no response is issued for the aborted op.
- len=1: the single shift bit carries TMS=1.
- len=MAX_LEN: the index counter must not overflow; it counts down from len-1.

Test Plan:
- Release reset, CLK_DIV=2 -> trst_ low until 1 clk after release; 6 tck rising edges with TMS 1,1,1,1,1,0; cmd_ready rises after the last falling edge; tck period = 4 clk.
- IR scan len=4, tdi=0xA, jtag_tdo tied 1 -> 10 rising edges; TMS 1,1,0,0,0,0,0,1,1,0; TDI on shift edges 0,1,0,1; rsp_tdo=0x0000000F.
- DR scan len=8, tdi=0x5A, bench TAP model with 1-bit bypass (tdo = tdi delayed one tck) -> 13 edges; rsp_tdo=0x000000B4 (bit0=bypass init 0).
- DR scan len=1 and len=32 (tdi=0x80000001, tdo tied 0) -> len=1: TMS on its only shift edge = 1, 6 edges total; len=32: 37 edges, rsp_tdo=0.
- Back-to-back commands with rsp_ready held low 10 clk -> tck stays low, rsp_valid held, cmd_ready=0; after rsp_ready, cmd_ready=1 the next clk.
- Assert reset_ midway through SHIFT of a len=16 DR scan -> tck=0, tms=1, trst_=0 immediately; after release, AUTO_TLR runs; no rsp_valid for the aborted op.

Source files
------------

// File: rtl/jtag_scan_master_if.sv
// rtl/jtag_scan_master_if.sv - command/response and JTAG pin bundle for jtag_scan_master
interface jtag_scan_master_if #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [LEN_W-1:0]   cmd_len;
   logic [MAX_LEN-1:0] cmd_tdi;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [MAX_LEN-1:0] rsp_tdo;
   logic               jtag_trst_;
   logic               jtag_tck;
   logic               jtag_tms;
   logic               jtag_tdi;
   logic               jtag_tdo;

   modport master (
      input  cmd_valid, cmd_op, cmd_len, cmd_tdi, rsp_ready, jtag_tdo,
      output cmd_ready, rsp_valid, rsp_tdo, jtag_trst_, jtag_tck, jtag_tms, jtag_tdi
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_len, cmd_tdi, rsp_ready, jtag_tdo,
      input  cmd_ready, rsp_valid, rsp_tdo, jtag_trst_, jtag_tck, jtag_tms, jtag_tdi
   );
endinterface

// File: rtl/jtag_scan_master.sv
// rtl/jtag_scan_master.sv - system-clock JTAG master running TLR/IR/DR scans from a command queue
module jtag_scan_master #(
   parameter int MAX_LEN = 32,
   parameter int CLK_DIV = 4,
   parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
   input  logic clk,
   input  logic reset_,
   jtag_scan_master_if.master bus
);
   localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   typedef enum logic [2:0] {S_AUTO_TLR, S_IDLE, S_TLR, S_HDR, S_SHIFT, S_TRL, S_RSP} state_t;

   state_t             r_state, w_state_nxt;
   logic [DIV_W-1:0]   r_div;
   logic               r_tck, r_trst_n;
   logic               r_tms, w_tms_nxt;
   logic               r_tdi, w_tdi_nxt;
   logic [2:0]         r_step, w_step_nxt;
   logic [IDX_W-1:0]   r_cnt, w_cnt_nxt;
   logic [IDX_W-1:0]   r_len_m1, w_len_m1_nxt;
   logic               r_is_ir, w_is_ir_nxt;
   logic [MAX_LEN-1:0] r_data, w_data_nxt;
   logic [MAX_LEN-1:0] r_tdo, w_tdo_nxt;

   logic               w_active, w_tick, w_rise, w_fall, w_len_ok;
   logic [IDX_W-1:0]   w_idx;
   logic [MAX_LEN-1:0] w_data_sh;

   assign w_active  = (r_state != S_IDLE) && (r_state != S_RSP);
   assign w_tick    = w_active && (r_div == DIV_W'(CLK_DIV - 1));
   assign w_rise    = w_tick && !r_tck;
   assign w_fall    = w_tick && r_tck;
   assign w_idx     = r_len_m1 - r_cnt;
   assign w_data_sh = r_data >> 1;
   assign w_len_ok  = (bus.cmd_len != '0) && (bus.cmd_len <= LEN_W'(MAX_LEN));

   // TCK only runs while a sequence is in flight, so it always parks low
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_div    <= '0;
         r_tck    <= 1'b0;
         r_trst_n <= 1'b0;
      end else begin
         r_trst_n <= 1'b1;
         if (!w_active) begin
            r_div <= '0;
         end else if (w_tick) begin
            r_div <= '0;
            r_tck <= ~r_tck;
         end else begin
            r_div <= r_div + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_state  <= S_AUTO_TLR;
         r_tms    <= 1'b1;
         r_tdi    <= 1'b0;
         r_step   <= '0;
         r_cnt    <= '0;
         r_len_m1 <= '0;
         r_is_ir  <= 1'b0;
         r_data   <= '0;
         r_tdo    <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_tms    <= w_tms_nxt;
         r_tdi    <= w_tdi_nxt;
         r_step   <= w_step_nxt;
         r_cnt    <= w_cnt_nxt;
         r_len_m1 <= w_len_m1_nxt;
         r_is_ir  <= w_is_ir_nxt;
         r_data   <= w_data_nxt;
         r_tdo    <= w_tdo_nxt;
      end
   end

   // Each bit's TMS/TDI is set up on the falling edge before the rising edge that uses it
   always_comb begin
      w_state_nxt  = r_state;
      w_tms_nxt    = r_tms;
      w_tdi_nxt    = r_tdi;
      w_step_nxt   = r_step;
      w_cnt_nxt    = r_cnt;
      w_len_m1_nxt = r_len_m1;
      w_is_ir_nxt  = r_is_ir;
      w_data_nxt   = r_data;
      w_tdo_nxt    = r_tdo;
      case (r_state)
         S_IDLE: begin
            if (bus.cmd_valid) begin
               w_is_ir_nxt  = (bus.cmd_op == 2'd1);
               w_len_m1_nxt = w_len_ok ? IDX_W'(bus.cmd_len - 1'b1) : IDX_W'(MAX_LEN - 1);
               w_data_nxt   = bus.cmd_tdi;
               w_tdo_nxt    = '0;
               w_step_nxt   = '0;
               w_tms_nxt    = 1'b1;
               w_tdi_nxt    = 1'b0;
               w_state_nxt  = (bus.cmd_op == 2'd1 || bus.cmd_op == 2'd2) ? S_HDR : S_TLR;
            end
         end
         S_AUTO_TLR, S_TLR: begin
            if (w_fall) begin
               if (r_step == 3'd5) begin
                  w_step_nxt  = '0;
                  w_state_nxt = (r_state == S_AUTO_TLR) ? S_IDLE : S_RSP;
               end else begin
                  w_step_nxt = r_step + 3'd1;
                  w_tms_nxt  = (r_step < 3'd4);
               end
            end
         end
         S_HDR: begin
            if (w_fall) begin
               if (r_step == (r_is_ir ? 3'd3 : 3'd2)) begin
                  w_step_nxt  = '0;
                  w_cnt_nxt   = r_len_m1;
                  w_tms_nxt   = (r_len_m1 == '0);
                  w_tdi_nxt   = r_data[0];
                  w_state_nxt = S_SHIFT;
               end else begin
                  w_step_nxt = r_step + 3'd1;
                  w_tms_nxt  = r_is_ir && (r_step == 3'd0);
               end
            end
         end
         S_SHIFT: begin
            if (w_rise) begin
               w_tdo_nxt[w_idx] = bus.jtag_tdo;
            end
            if (w_fall) begin
               if (r_cnt == '0) begin
                  w_tms_nxt   = 1'b1;
                  w_tdi_nxt   = 1'b0;
                  w_state_nxt = S_TRL;
               end else begin
                  w_cnt_nxt  = r_cnt - 1'b1;
                  w_data_nxt = w_data_sh;
                  w_tdi_nxt  = w_data_sh[0];
                  w_tms_nxt  = (r_cnt == IDX_W'(1));
               end
            end
         end
         S_TRL: begin
            if (w_fall) begin
               if (r_step == 3'd0) begin
                  w_step_nxt = 3'd1;
                  w_tms_nxt  = 1'b0;
               end else begin
                  w_step_nxt  = '0;
                  w_state_nxt = S_RSP;
               end
            end
         end
         S_RSP: begin
            if (bus.rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_AUTO_TLR;
      endcase
   end

   assign bus.cmd_ready  = (r_state == S_IDLE);
   assign bus.rsp_valid  = (r_state == S_RSP);
   assign bus.rsp_tdo    = r_tdo;
   assign bus.jtag_trst_ = r_trst_n;
   assign bus.jtag_tck   = r_tck;
   assign bus.jtag_tms   = r_tms;
   assign bus.jtag_tdi   = r_tdi;
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb/tb_jtag_scan_master.sv - self-checking bench for jtag_scan_master
module tb_jtag_scan_master;
   localparam int MAXL = 32;
   localparam int CDIV = 2;

   logic clk = 1'b0;
   logic reset_ = 1'b0;
   always #5 clk = ~clk;

   jtag_scan_master_if #(.MAX_LEN(MAXL)) bus ();

   jtag_scan_master #(.MAX_LEN(MAXL), .CLK_DIV(CDIV)) dut (
      .clk    (clk),
      .reset_ (reset_),
      .bus    (bus.master)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // target model: 0 tie low, 1 tie high, 2 one-bit bypass, 3 random per edge
   int   tdo_mode = 0;
   logic r_byp = 1'b0;
   logic r_rnd = 1'b0;
   assign bus.jtag_tdo = (tdo_mode == 1) | ((tdo_mode == 2) & r_byp) | ((tdo_mode == 3) & r_rnd);

   int   cyc = 0;
   int   n_edges = 0;
   int   rsp_cycles = 0;
   logic e_tms [4096];
   logic e_tdi [4096];
   logic e_tdo [4096];
   int   e_cyc [4096];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.rsp_valid) rsp_cycles <= rsp_cycles + 1;

   always @(posedge bus.jtag_tck) begin
      if (n_edges < 4096) begin
         e_tms[n_edges] <= bus.jtag_tms;
         e_tdi[n_edges] <= bus.jtag_tdi;
         e_tdo[n_edges] <= bus.jtag_tdo;
         e_cyc[n_edges] <= cyc;
      end
      n_edges <= n_edges + 1;
      r_byp   <= bus.jtag_tdi;
      r_rnd   <= 1'($urandom);
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // Expected pin sequence and capture derived from the scan rules, compared edge by edge
   task automatic check_model(input logic [1:0] op, input logic [5:0] len, input logic [31:0] tdi,
                              input int start, input logic [31:0] rsp);
      int L, hdr, total, got_n, lim, bad, badp, i;
      logic exp_tms, exp_tdi;
      logic [31:0] exp_rsp;
      bit scan;
      scan  = (op == 2'd1) || (op == 2'd2);
      L     = (len == 0 || len > MAXL) ? MAXL : int'(len);
      hdr   = (op == 2'd1) ? 4 : 3;
      total = scan ? hdr + L + 2 : 6;
      got_n = n_edges - start;
      check("edge count vs model", got_n, total);
      lim = (got_n < total) ? got_n : total;
      bad = 0; badp = 0; exp_rsp = '0;
      for (int e = 0; e < lim; e++) begin
         exp_tdi = 1'b0;
         if (!scan) begin
            exp_tms = (e < 5);
         end else if (e < hdr) begin
            exp_tms = (op == 2'd1) ? (e < 2) : (e == 0);
         end else if (e < hdr + L) begin
            i = e - hdr;
            exp_tms = (i == L - 1);
            exp_tdi = tdi[i];
            exp_rsp[i] = e_tdo[start + e];
         end else begin
            exp_tms = (e == hdr + L);
         end
         if (e_tms[start + e] !== exp_tms || e_tdi[start + e] !== exp_tdi) bad++;
         if (e > 0 && (e_cyc[start + e] - e_cyc[start + e - 1]) != 2 * CDIV) badp++;
      end
      check("tms/tdi sequence errors", bad, 0);
      check("tck period errors", badp, 0);
      check("rsp_tdo vs model", rsp, exp_rsp);
   endtask

   task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [31:0] tdi,
                          input int mode, input int hold, output logic [31:0] rsp, output int start);
      int k, bad, e0;
      tdo_mode = mode;
      k = 0;
      while (!bus.cmd_ready && k < 500) begin @(negedge clk); k++; end
      check("cmd_ready before command", bus.cmd_ready, 1);
      start = n_edges;
      bus.cmd_op = op; bus.cmd_len = len; bus.cmd_tdi = tdi; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      check("cmd_ready drops after accept", bus.cmd_ready, 0);
      k = 0;
      while (!bus.rsp_valid && k < 1000) begin @(negedge clk); k++; end
      check("rsp_valid within budget", bus.rsp_valid, 1);
      rsp = bus.rsp_tdo;
      if (hold > 0) begin
         bad = 0; e0 = n_edges;
         bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2;
         repeat (hold) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.cmd_ready || bus.jtag_tck || bus.rsp_tdo !== rsp) bad++;
         end
         bus.cmd_valid = 1'b0;
         check("rsp held stable while not ready", bad, 0);
         check("no tck edges while rsp pending", n_edges - e0, 0);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      check("cmd_ready one clk after rsp handshake", bus.cmd_ready, 1);
   endtask

   typedef struct {
      logic [1:0]  op;
      logic [5:0]  len;
      logic [31:0] tdi;
      int          mode;
      int          hold;
      int          edges;
      logic [31:0] rsp;
   } vec_t;

   initial begin
      vec_t        tbl [9];
      logic [31:0] rsp;
      int          start, k, rc;
      logic [1:0]  rop;
      logic [5:0]  rlen;

      tbl[0] = '{2'd1, 6'd4,  32'h0000_000A, 1, 0,  10, 32'h0000_000F};
      tbl[1] = '{2'd2, 6'd8,  32'h0000_005A, 2, 10, 13, 32'h0000_00B4};
      tbl[2] = '{2'd2, 6'd1,  32'h0000_0001, 1, 0,  6,  32'h0000_0001};
      tbl[3] = '{2'd2, 6'd32, 32'h8000_0001, 0, 0,  37, 32'h0000_0000};
      tbl[4] = '{2'd0, 6'd5,  32'hFFFF_FFFF, 1, 0,  6,  32'h0000_0000};
      tbl[5] = '{2'd3, 6'd9,  32'h1234_5678, 1, 0,  6,  32'h0000_0000};
      tbl[6] = '{2'd2, 6'd0,  32'hDEAD_BEEF, 1, 0,  37, 32'hFFFF_FFFF};
      tbl[7] = '{2'd1, 6'd40, 32'h0F0F_0F0F, 1, 0,  38, 32'hFFFF_FFFF};
      tbl[8] = '{2'd1, 6'd1,  32'h0000_0001, 2, 0,  7,  32'h0000_0000};

      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_len = '0; bus.cmd_tdi = '0;
      bus.rsp_ready = 1'b0;

      repeat (3) @(negedge clk);
      check("reset trst_", bus.jtag_trst_, 0);
      check("reset tck", bus.jtag_tck, 0);
      check("reset tms", bus.jtag_tms, 1);
      check("reset tdi", bus.jtag_tdi, 0);
      check("reset cmd_ready", bus.cmd_ready, 0);
      check("reset rsp_valid", bus.rsp_valid, 0);
      check("reset rsp_tdo", bus.rsp_tdo, 0);

      reset_ = 1'b1;
      #1;
      check("trst_ low until first clk", bus.jtag_trst_, 0);
      @(negedge clk);
      check("trst_ high after first clk", bus.jtag_trst_, 1);
      k = 0;
      while (!bus.cmd_ready && k < 500) begin @(negedge clk); k++; end
      check("cmd_ready after auto TLR", bus.cmd_ready, 1);
      check("tck low when ready", bus.jtag_tck, 0);
      check("no rsp for auto TLR", rsp_cycles, 0);
      check_model(2'd0, 6'd0, 32'h0, 0, bus.rsp_tdo);

      for (int t = 0; t < 9; t++) begin
         run_cmd(tbl[t].op, tbl[t].len, tbl[t].tdi, tbl[t].mode, tbl[t].hold, rsp, start);
         check("edge count vs table", n_edges - start, tbl[t].edges);
         check("rsp_tdo vs table", rsp, tbl[t].rsp);
         check_model(tbl[t].op, tbl[t].len, tbl[t].tdi, start, rsp);
      end

      for (int t = 0; t < 24; t++) begin
         rop  = 2'($urandom_range(0, 3));
         rlen = 6'($urandom_range(0, 63));
         run_cmd(rop, rlen, $urandom, int'($urandom_range(0, 3)), 0, rsp, start);
         check_model(rop, rlen, bus.cmd_tdi, start, rsp);
      end

      // Abort a len=16 DR scan in the middle of its shift phase
      tdo_mode = 1;
      start = n_edges;
      bus.cmd_op = 2'd2; bus.cmd_len = 6'd16; bus.cmd_tdi = 32'h0000_A5A5; bus.cmd_valid = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      k = 0;
      while (n_edges < start + 11 && k < 500) begin @(negedge clk); k++; end
      check("reached mid-shift", n_edges - start, 11);
      rc = rsp_cycles;
      reset_ = 1'b0;
      #1;
      check("abort tck", bus.jtag_tck, 0);
      check("abort tms", bus.jtag_tms, 1);
      check("abort trst_", bus.jtag_trst_, 0);
      check("abort cmd_ready", bus.cmd_ready, 0);
      repeat (3) @(negedge clk);
      reset_ = 1'b1;
      start = n_edges;
      k = 0;
      while (!bus.cmd_ready && k < 500) begin @(negedge clk); k++; end
      check("cmd_ready after re-sync", bus.cmd_ready, 1);
      check_model(2'd0, 6'd0, 32'h0, start, bus.rsp_tdo);
      check("no rsp for aborted op", rsp_cycles - rc, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
